// File: rtl/conv1_win_seq_ctrl.sv
// conv1_win_seq_ctrl: walks a KxK window over the input map, fetching K rows per output
// pixel, loading the flop bank, firing the MAC and handing the (row, col) downstream.
//   conv1_ctrl_clk / conv1_ctrl_rst_b : clock, asynchronous active-low reset
//   start_i, busy_o, done_o           : pass control and status
//   rd_en_o, rd_addr_o                : input line-buffer read port (1-cycle latency)
//   intrm_flop_en_o, intrm_flop_sel_o : row-slot load into the intermediate flop bank
//   mac_en_o                          : single-cycle MAC fire
//   out_valid_o, out_ready_i, out_row_o, out_col_o : output coordinate handshake
//   stall_cnt_o                       : present only with CONV1_CTRL_STALL_CNT_EN defined
module conv1_win_seq_ctrl #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int ADDR_W = 10,
    localparam int OUT_W = IMG_W - K + 1,
    localparam int OUT_H = IMG_H - K + 1,
    localparam int SEL_W = $clog2(K),
    localparam int OR_W  = $clog2(OUT_H),
    localparam int OC_W  = $clog2(OUT_W)
) (
    input  logic              conv1_ctrl_clk,
    input  logic              conv1_ctrl_rst_b,
    input  logic              start_i,
    output logic              busy_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              intrm_flop_en_o,
    output logic [SEL_W-1:0]  intrm_flop_sel_o,
    output logic              mac_en_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OR_W-1:0]   out_row_o,
    output logic [OC_W-1:0]   out_col_o,
    output logic              done_o
`ifdef CONV1_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, MAC, OUT, DONE} state_t;

    state_t             state_q, state_d;
    logic [OR_W-1:0]    r_q, r_d;
    logic [OC_W-1:0]    c_q, c_d;
    logic [SEL_W-1:0]   k_q, k_d;
    logic               intrm_flop_en_q, intrm_flop_en_d;
    logic [SEL_W-1:0]   intrm_flop_sel_q, intrm_flop_sel_d;
    logic               last_k, last_c, last_r;

    assign last_k = k_q == SEL_W'(K - 1);
    assign last_c = c_q == OC_W'(OUT_W - 1);
    assign last_r = r_q == OR_W'(OUT_H - 1);

    always_comb begin
        state_d          = state_q;
        r_d              = r_q;
        c_d              = c_q;
        k_d              = k_q;
        busy_o           = 1'b0;
        rd_en_o          = 1'b0;
        mac_en_o         = 1'b0;
        out_valid_o      = 1'b0;
        done_o           = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            FETCH: begin
                busy_o  = 1'b1;
                rd_en_o = 1'b1;
                k_d     = last_k ? '0 : k_q + SEL_W'(1);
                state_d = last_k ? DRAIN : FETCH;
            end
            DRAIN: begin
                busy_o  = 1'b1;
                state_d = MAC;
            end
            MAC: begin
                busy_o   = 1'b1;
                mac_en_o = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    k_d     = '0;
                    c_d     = last_c ? '0 : c_q + OC_W'(1);
                    r_d     = last_c ? r_q + OR_W'(1) : r_q;
                    state_d = (last_c && last_r) ? DONE : FETCH;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Buffer returns data one cycle after the strobe, so the load lags the fetch.
        intrm_flop_en_d  = rd_en_o;
        intrm_flop_sel_d = k_q;
    end

    // Address and coordinates are forced to zero outside their active states.
    assign rd_addr_o = (state_q == FETCH)
                     ? ADDR_W'((32'(r_q) + 32'(k_q)) * 32'(IMG_W) + 32'(c_q)) : '0;
    assign out_row_o        = (state_q == OUT) ? r_q : '0;
    assign out_col_o        = (state_q == OUT) ? c_q : '0;
    assign intrm_flop_en_o  = intrm_flop_en_q;
    assign intrm_flop_sel_o = intrm_flop_sel_q;

    always_ff @(posedge conv1_ctrl_clk or negedge conv1_ctrl_rst_b) begin
        if (!conv1_ctrl_rst_b) begin
            state_q          <= IDLE;
            r_q              <= '0;
            c_q              <= '0;
            k_q              <= '0;
            intrm_flop_en_q  <= 1'b0;
            intrm_flop_sel_q <= '0;
        end else begin
            state_q          <= state_d;
            r_q              <= r_d;
            c_q              <= c_d;
            k_q              <= k_d;
            intrm_flop_en_q  <= intrm_flop_en_d;
            intrm_flop_sel_q <= intrm_flop_sel_d;
        end
    end

`ifdef CONV1_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start_i)
            stall_cnt_d = '0;
        else if (out_valid_o && !out_ready_i && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge conv1_ctrl_clk or negedge conv1_ctrl_rst_b) begin
        if (!conv1_ctrl_rst_b) stall_cnt_q <= '0;
        else                   stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_conv1_win_seq_ctrl.sv
// tb_conv1_win_seq_ctrl: scoreboard bench for the conv1 window sequencer at default parameters.
module tb_conv1_win_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start_i = 1'b0;
    logic       out_ready_i = 1'b1;
    logic       busy_o, rd_en_o, intrm_flop_en_o, mac_en_o, out_valid_o, done_o;
    logic [9:0] rd_addr_o;
    logic [2:0] intrm_flop_sel_o;
    logic [4:0] out_row_o, out_col_o;
`ifdef CONV1_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    conv1_win_seq_ctrl dut (
        .conv1_ctrl_clk   (clk),
        .conv1_ctrl_rst_b (rst_b),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .rd_en_o          (rd_en_o),
        .rd_addr_o        (rd_addr_o),
        .intrm_flop_en_o  (intrm_flop_en_o),
        .intrm_flop_sel_o (intrm_flop_sel_o),
        .mac_en_o         (mac_en_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_row_o        (out_row_o),
        .out_col_o        (out_col_o),
        .done_o           (done_o)
`ifdef CONV1_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] c;
        logic [9:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   hs = 0;
    int   hs0 = 0;

    logic       pv = 1'b0, pr = 1'b0, prd = 1'b0;
    logic [4:0] prow = '0, pcol = '0;
    logic [9:0] first = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string nm, input int act, input int expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // Monitor: latches the first fetch address of each pixel, checks hold-under-stall,
    // and pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_en_o && !prd) first = rd_addr_o;
            if (pv && !pr) begin
                chk(out_valid_o, "valid_hold", int'(out_valid_o), 1);
                chk(out_row_o == prow && out_col_o == pcol, "coord_hold",
                    int'({out_row_o, out_col_o}), int'({prow, pcol}));
            end
            if (out_valid_o && out_ready_i) begin
                chk(exp_q.size() > 0, "queue_underflow", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(out_row_o == e.r, "out_row", int'(out_row_o), int'(e.r));
                    chk(out_col_o == e.c, "out_col", int'(out_col_o), int'(e.c));
                    chk(first == e.a, "first_addr", int'(first), int'(e.a));
                end
                hs++;
            end
            pv   = out_valid_o;
            pr   = out_ready_i;
            prd  = rd_en_o;
            prow = out_row_o;
            pcol = out_col_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises start for one cycle; on return the bench sits in cycle 1 of the pass.
    task automatic start_pass();
        exp_t e;
        start_i = 1'b1;
        t0      = cyc;
        hs0     = hs;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                e.r = 5'(r);
                e.c = 5'(c);
                e.a = 10'(r * 32 + c);
                exp_q.push_back(e);
            end
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        for (int i = 0; i < 20000 && hs - hs0 < n; i++) step();
        chk(hs - hs0 >= n, "hs_wait", hs - hs0, n);
    endtask

    task automatic wait_done(input int exp_cyc);
        for (int i = 0; i < 8000 && !done_o; i++) step();
        chk(done_o, "done_seen", int'(done_o), 1);
        chk(cyc - t0 == exp_cyc, "done_cycle", cyc - t0, exp_cyc);
        chk(!busy_o, "busy_at_done", int'(busy_o), 0);
        step();
        chk(!done_o, "done_pulse", int'(done_o), 0);
        chk(exp_q.size() == 0, "outputs_left", exp_q.size(), 0);
    endtask

    initial begin
        step();
        chk(!busy_o && !rd_en_o && !mac_en_o, "rst_ctrl", int'({busy_o, rd_en_o, mac_en_o}), 0);
        chk(!out_valid_o && !done_o && !intrm_flop_en_o, "rst_out",
            int'({out_valid_o, done_o, intrm_flop_en_o}), 0);
        chk(rd_addr_o == 0, "rst_addr", int'(rd_addr_o), 0);
        rst_b = 1'b1;
        step();
        chk(!busy_o, "idle_busy", int'(busy_o), 0);

        // Pass 1: first-pixel timing, mid-pass start ignored, full-pass length.
        start_pass();
        for (int n = 1; n <= 8; n++) begin
            chk(rd_en_o == (n <= 5), $sformatf("rd_en_c%0d", n), int'(rd_en_o), int'(n <= 5));
            if (n <= 5)
                chk(rd_addr_o == 10'((n - 1) * 32), $sformatf("addr_c%0d", n),
                    int'(rd_addr_o), (n - 1) * 32);
            chk(intrm_flop_en_o == (n >= 2 && n <= 6), $sformatf("flop_en_c%0d", n),
                int'(intrm_flop_en_o), int'(n >= 2 && n <= 6));
            if (n >= 2 && n <= 6)
                chk(intrm_flop_sel_o == 3'(n - 2), $sformatf("sel_c%0d", n),
                    int'(intrm_flop_sel_o), n - 2);
            chk(mac_en_o == (n == 7), $sformatf("mac_c%0d", n), int'(mac_en_o), int'(n == 7));
            chk(out_valid_o == (n == 8), $sformatf("valid_c%0d", n), int'(out_valid_o), int'(n == 8));
            chk(busy_o, $sformatf("busy_c%0d", n), int'(busy_o), 1);
            step();
        end
        repeat (100) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk(busy_o, "busy_mid", int'(busy_o), 1);
        wait_done(6273);

        // Pass 2: ten-cycle stall on pixel (3,4).
        step();
        start_pass();
        wait_hs(3 * 28 + 4);
        out_ready_i = 1'b0;
        for (int i = 0; i < 20 && !out_valid_o; i++) step();
        chk(out_valid_o, "stall_valid", int'(out_valid_o), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk(out_valid_o && out_row_o == 5'd3 && out_col_o == 5'd4, "stall_coord",
                int'({out_valid_o, out_row_o, out_col_o}), int'({1'b1, 5'd3, 5'd4}));
            chk(!rd_en_o, "stall_no_read", int'(rd_en_o), 0);
        end
        out_ready_i = 1'b1;
        wait_done(6283);
`ifdef CONV1_CTRL_STALL_CNT_EN
        chk(stall_cnt_o == 32'd10, "stall_cnt", int'(stall_cnt_o), 10);
`endif

        // Pass 3: asynchronous reset during the fetch of (5,9).
        step();
        start_pass();
        wait_hs(5 * 28 + 9);
        step();
        chk(rd_en_o && rd_addr_o == 10'd201, "fetch_5_9", int'(rd_addr_o), 201);
        rst_b = 1'b0;
        #1;
        chk(!busy_o && !rd_en_o && !intrm_flop_en_o && !mac_en_o && !out_valid_o && !done_o,
            "arst_ctrl", int'({busy_o, rd_en_o, intrm_flop_en_o, mac_en_o, out_valid_o, done_o}), 0);
        chk(rd_addr_o == 0 && intrm_flop_sel_o == 0 && out_row_o == 0 && out_col_o == 0,
            "arst_data", int'(rd_addr_o), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk(!done_o && !busy_o, "arst_hold", int'({done_o, busy_o}), 0);
        end
        exp_q.delete();
        rst_b = 1'b1;
        step();
        chk(!busy_o, "no_autostart", int'(busy_o), 0);

        // Pass 4: fresh start after the abort begins again at (0,0).
        start_pass();
        chk(rd_en_o && rd_addr_o == 10'd0, "restart_addr", int'(rd_addr_o), 0);
        wait_done(6273);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv1_win_seq_ctrl.md
Name: conv1_win_seq_ctrl

Overview:
Sequencer for the conv1 stage of the LeNet datapath. Walks a KxK window over an IMG_W x IMG_H input feature map. For each output pixel it issues K row reads to the input buffer, loads the returned rows into the conv1 intermediate flop bank one row-slot at a time, fires one MAC cycle, then presents the output coordinate to the downstream consumer under a valid/ready handshake.
Sits between the input line buffer (1-cycle read latency) and the conv1 intermediate-flop / MAC array.

Parameters:
IMG_W, 32, input feature-map width in pixels
IMG_H, 32, input feature-map height in pixels
K, 5, kernel size; window is KxK, flop bank holds K row-slots
ADDR_W, 10, input buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
Derived (localparam, not overridable): OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1, SEL_W = $clog2(K), OR_W = $clog2(OUT_H), OC_W = $clog2(OUT_W)

Ports:
conv1_ctrl_clk  in  1  clock, all logic on rising edge
conv1_ctrl_rst_b  in  1  asynchronous active-low reset
start_i  in  1  start one full feature-map pass; sampled in IDLE only
busy_o  out  1  high from the cycle after accepted start until done_o
rd_en_o  out  1  input buffer read strobe
rd_addr_o  out  ADDR_W  input buffer address, row-major, (r+k)*IMG_W + c
intrm_flop_en_o  out  1  load enable to the intermediate flop bank
intrm_flop_sel_o  out  SEL_W  row-slot index 0..K-1 being loaded
mac_en_o  out  1  one-cycle MAC fire over the loaded window
out_valid_o  out  1  output coordinate valid
out_ready_i  in  1  downstream accepts
out_row_o  out  OR_W  output pixel row r
out_col_o  out  OC_W  output pixel column c
done_o  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0; state IDLE; r = c = k = 0. Reset asserted mid-pass aborts immediately, with no done_o. The pass restarts only on a new start_i.
- States:
  - IDLE -> FETCH on start_i (r = c = k = 0).
  - FETCH: rd_en_o = 1, rd_addr_o = (r+k)*IMG_W + c. Increments k for K cycles, then goes to DRAIN.
  - DRAIN: 1 cycle, no read. Goes to MAC.
  - MAC: mac_en_o = 1 for 1 cycle. Goes to OUT.
  - OUT: out_valid_o = 1 with out_row_o = r, out_col_o = c, both held stable until out_ready_i.
    - On handshake: if c = OUT_W-1, then c = 0 and r++; otherwise c++. k = 0.
    - If the handshake is on (r, c) = (OUT_H-1, OUT_W-1), go to DONE; otherwise go to FETCH.
  - DONE: done_o = 1 for 1 cycle, busy_o drops the same cycle. Goes to IDLE.
- Flop load: intrm_flop_en_o and intrm_flop_sel_o are rd_en_o and k registered by one cycle, matching the 1-cycle buffer latency. Slot K-1 therefore loads during DRAIN.
- Latency:
  - First rd_en_o occurs 1 cycle after start_i.
  - Per pixel, minimum K+3 cycles (5+3 = 8 at defaults).
  - Full pass at defaults with out_ready_i tied high: 784*8 = 6272 cycles, then the DONE cycle.
- Handshake: out_valid_o never drops without out_ready_i. out_ready_i outside OUT is ignored.
- start_i while busy_o is ignored. start_i during the DONE cycle is ignored; it must be re-asserted in IDLE.
- Address arithmetic is unsigned. The maximum address (IMG_H-1)*IMG_W + OUT_W-1 always fits ADDR_W.

Optional Feature:
Macro CONV1_CTRL_STALL_CNT_EN.
- Defined: adds output port stall_cnt_o (32 bits).
  - Counts cycles with out_valid_o=1 and out_ready_i=0.
  - Clears to 0 on accepted start_i and on reset.
  - Saturates at 2^32-1.
  - Holds its value after done_o.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then start_i pulse, out_ready_i=1 -> rd_addr_o sequence 0,32,64,96,128 on cycles 1-5. intrm_flop_sel_o 0..4 on cycles 2-6. mac_en_o on cycle 7. out_valid_o on cycle 8 with (0,0).
- Full pass, out_ready_i=1 -> 784 handshakes in raster order, the last being (27,27) with addr of its first fetch = 27*32+27 = 891. done_o at cycle 6273 after start.
- Row wrap -> handshake on (0,27) is followed by a fetch at addr 32, and the next output is (1,0).
- out_ready_i held low 10 cycles at (3,4) -> out_valid_o and coordinates stable, no rd_en_o. With CONV1_CTRL_STALL_CNT_EN, stall_cnt_o = 10.
- start_i re-pulsed mid-pass -> ignored; sequence and done_o timing unchanged.
- conv1_ctrl_rst_b low during FETCH of (5,9) -> all outputs 0 asynchronously. No done_o; next start_i begins at (0,0).
